fast_segment_test: RTL and testbench

Serial FAST-9 segment-test engine for the corner pipeline. It accepts one candidate centre pixel plus its 16 Bresenham-ring neighbours, streamed one per cycle from the pixel-position/SRAM read stage. It decides whether the ring holds N contiguous pixels (with wrap-around) all brighter or all darker than the centre by more than a threshold. It then reports a corner flag and score for the downstream corner-map (SRAM4) write.

---
 rtl/fast_pkg.sv | 37 +++
 rtl/fast_segment_test_if.sv | 28 ++
 rtl/fast_run_tracker.sv | 64 ++++++
 rtl/fast_segment_test.sv | 156 +++++++++++++++
 tb/tb_fast_segment_test.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fast_pkg.sv
// Shared FAST segment-test definitions: ring geometry, run widths and FSM states.
package fast_pkg;

  localparam int unsigned RING_LEN = 16;
  // Run lengths go 0..RING_LEN inclusive.
  localparam int unsigned RUN_W = $clog2(RING_LEN + 1);

  // Radius-3 Bresenham ring, index 0 at dy = -3, clockwise; used by the address generator.
  localparam int RING_DX [RING_LEN] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  localparam int RING_DY [RING_LEN] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StEval
  } seg_state_t;

  // Longest circular arc from the run-tracker summary.
  function automatic logic [RUN_W-1:0] arc_len(input logic [RUN_W-1:0] cur_run,
                                               input logic [RUN_W-1:0] first_run,
                                               input logic [RUN_W-1:0] max_run,
                                               input logic             all_hit);
    logic [RUN_W-1:0] arc;
    logic [RUN_W-1:0] joined;
    if (all_hit) begin
      arc = RUN_W'(RING_LEN);
    end else begin
      // Not all hit, so the leading and trailing runs together stay below RING_LEN.
      joined = cur_run + first_run;
      arc    = max_run;
      if (cur_run > arc) arc = cur_run;
      if (joined > arc) arc = joined;
    end
    return arc;
  endfunction

endpackage

// File: rtl/fast_segment_test_if.sv
// Handshake/result bundle between the pixel read stage and the segment-test engine.
interface fast_segment_test_if #(
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned SCORE_W = 12
) ();

  logic               start;
  logic [PIX_W-1:0]   center;
  logic [PIX_W-1:0]   thresh;
  logic               pix_valid;
  logic [PIX_W-1:0]   pix_in;
  logic [3:0]         ring_idx;
  logic               busy;
  logic               done;
  logic               is_corner;
  logic [SCORE_W-1:0] score;

  modport master (
    output start, center, thresh, pix_valid, pix_in,
    input  ring_idx, busy, done, is_corner, score
  );

  modport slave (
    input  start, center, thresh, pix_valid, pix_in,
    output ring_idx, busy, done, is_corner, score
  );

endinterface

// File: rtl/fast_run_tracker.sv
// Tracks current, leading and longest run of consecutive hits around the ring.
module fast_run_tracker
  import fast_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             hit_i,
  input  logic             step_i,
  output logic [RUN_W-1:0] cur_run_o,
  output logic [RUN_W-1:0] first_run_o,
  output logic [RUN_W-1:0] max_run_o,
  output logic             all_hit_o
);

  logic [RUN_W-1:0] cur_q, cur_d;
  logic [RUN_W-1:0] first_q, first_d;
  logic [RUN_W-1:0] max_q, max_d;
  logic             open_q, open_d;  // no miss seen yet, leading run still growing

  // Next-state: extend runs on a hit, close the current run on a miss.
  always_comb begin
    cur_d   = cur_q;
    first_d = first_q;
    max_d   = max_q;
    open_d  = open_q;
    if (clear_i) begin
      cur_d   = '0;
      first_d = '0;
      max_d   = '0;
      open_d  = 1'b1;
    end else if (step_i) begin
      if (hit_i) begin
        cur_d = cur_q + 1'b1;
        if (open_q) first_d = first_q + 1'b1;
      end else begin
        if (cur_q > max_q) max_d = cur_q;
        cur_d  = '0;
        open_d = 1'b0;
      end
    end
  end

  // Run registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_q   <= '0;
      first_q <= '0;
      max_q   <= '0;
      open_q  <= 1'b1;
    end else begin
      cur_q   <= cur_d;
      first_q <= first_d;
      max_q   <= max_d;
      open_q  <= open_d;
    end
  end

  assign cur_run_o   = cur_q;
  assign first_run_o = first_q;
  assign max_run_o   = max_q;
  assign all_hit_o   = open_q;

endmodule

// File: rtl/fast_segment_test.sv
// Serial FAST segment test: collects 16 ring pixels, reports corner flag and score.
module fast_segment_test
  import fast_pkg::*;
#(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned N_CONTIG = 9,
  parameter int unsigned SCORE_W  = 12
) (
  input logic                clk,
  input logic                n_rst,   // synchronous, active-high
  fast_segment_test_if.slave seg_if
);

  localparam int unsigned CalcW = PIX_W + 2;

  seg_state_t         state_q, state_d;
  logic [PIX_W-1:0]   center_q, center_d;
  logic [PIX_W-1:0]   thresh_q, thresh_d;
  logic [3:0]         ring_idx_q, ring_idx_d;
  logic               done_q, done_d;
  logic               corner_q, corner_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] bsum_q, bsum_d;
  logic [SCORE_W-1:0] dsum_q, dsum_d;

  logic accept_start, accept_pix;
  logic bright, dark;
  logic signed [CalcW-1:0] p_s, hi_s, lo_s, bdiff_s, ddiff_s;
  logic [SCORE_W-1:0] badd, dadd;

  logic [RUN_W-1:0] b_cur, b_first, b_max, d_cur, d_first, d_max;
  logic             b_all, d_all;
  logic [RUN_W-1:0] b_arc, d_arc;
  logic             b_ok, d_ok;

  assign accept_start = (state_q == StIdle) && seg_if.start;
  assign accept_pix   = (state_q == StCollect) && seg_if.pix_valid;

  // Widened signed compare so c + t and c - t never wrap.
  always_comb begin
    p_s     = signed'({2'b00, seg_if.pix_in});
    hi_s    = signed'({2'b00, center_q}) + signed'({2'b00, thresh_q});
    lo_s    = signed'({2'b00, center_q}) - signed'({2'b00, thresh_q});
    bright  = p_s > hi_s;
    dark    = p_s < lo_s;
    bdiff_s = p_s - hi_s;
    ddiff_s = lo_s - p_s;
    badd    = SCORE_W'(unsigned'(bdiff_s));
    dadd    = SCORE_W'(unsigned'(ddiff_s));
  end

  fast_run_tracker u_bright (
    .clk_i       (clk),
    .rst_i       (n_rst),
    .clear_i     (accept_start),
    .hit_i       (bright),
    .step_i      (accept_pix),
    .cur_run_o   (b_cur),
    .first_run_o (b_first),
    .max_run_o   (b_max),
    .all_hit_o   (b_all)
  );

  fast_run_tracker u_dark (
    .clk_i       (clk),
    .rst_i       (n_rst),
    .clear_i     (accept_start),
    .hit_i       (dark),
    .step_i      (accept_pix),
    .cur_run_o   (d_cur),
    .first_run_o (d_first),
    .max_run_o   (d_max),
    .all_hit_o   (d_all)
  );

  assign b_arc = arc_len(b_cur, b_first, b_max, b_all);
  assign d_arc = arc_len(d_cur, d_first, d_max, d_all);
  assign b_ok  = 32'(b_arc) >= N_CONTIG;
  assign d_ok  = 32'(d_arc) >= N_CONTIG;

  // FSM next-state, pixel accumulation and result capture.
  always_comb begin
    state_d    = state_q;
    center_d   = center_q;
    thresh_d   = thresh_q;
    ring_idx_d = ring_idx_q;
    done_d     = 1'b0;
    corner_d   = corner_q;
    score_d    = score_q;
    bsum_d     = bsum_q;
    dsum_d     = dsum_q;
    unique case (state_q)
      StIdle: begin
        if (seg_if.start) begin
          state_d    = StCollect;
          center_d   = seg_if.center;
          thresh_d   = seg_if.thresh;
          ring_idx_d = '0;
          corner_d   = 1'b0;
          score_d    = '0;
          bsum_d     = '0;
          dsum_d     = '0;
        end
      end
      StCollect: begin
        if (seg_if.pix_valid) begin
          ring_idx_d = ring_idx_q + 1'b1;  // wraps to 0 after the last pixel
          if (bright) bsum_d = bsum_q + badd;
          if (dark)   dsum_d = dsum_q + dadd;
          if (ring_idx_q == 4'd15) state_d = StEval;
        end
      end
      StEval: begin
        state_d  = StIdle;
        done_d   = 1'b1;
        corner_d = b_ok || d_ok;
        if (b_ok)      score_d = bsum_q;
        else if (d_ok) score_d = dsum_q;
        else           score_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q    <= StIdle;
      center_q   <= '0;
      thresh_q   <= '0;
      ring_idx_q <= '0;
      done_q     <= 1'b0;
      corner_q   <= 1'b0;
      score_q    <= '0;
      bsum_q     <= '0;
      dsum_q     <= '0;
    end else begin
      state_q    <= state_d;
      center_q   <= center_d;
      thresh_q   <= thresh_d;
      ring_idx_q <= ring_idx_d;
      done_q     <= done_d;
      corner_q   <= corner_d;
      score_q    <= score_d;
      bsum_q     <= bsum_d;
      dsum_q     <= dsum_d;
    end
  end

  assign seg_if.ring_idx  = ring_idx_q;
  assign seg_if.busy      = (state_q != StIdle);
  assign seg_if.done      = done_q;
  assign seg_if.is_corner = corner_q;
  assign seg_if.score     = score_q;

endmodule

// File: tb/tb_fast_segment_test.sv
// Bench for fast_segment_test: cycle model from the segment-test rules plus directed cases.
module tb_fast_segment_test;

  localparam int PW = 8;
  localparam int SW = 12;
  localparam int NC = 9;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  fast_segment_test_if #(.PIX_W(PW), .SCORE_W(SW)) sif ();

  fast_segment_test #(.PIX_W(PW), .N_CONTIG(NC), .SCORE_W(SW)) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .seg_if (sif)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit init = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Longest circular run of set flags.
  function automatic int arc_of(input bit h[16]);
    int best = 0;
    for (int i = 0; i < 16; i++) begin
      int k = 0;
      while (k < 16 && h[(i + k) % 16]) k++;
      if (k > best) best = k;
    end
    return best;
  endfunction

  function automatic void ref_result(input int c, input int t, input int p[16],
                                     output bit corner, output int score);
    bit br[16];
    bit dk[16];
    int bs = 0;
    int ds = 0;
    for (int i = 0; i < 16; i++) begin
      br[i] = p[i] > c + t;
      dk[i] = p[i] < c - t;
      if (br[i]) bs += p[i] - c - t;
      if (dk[i]) ds += c - p[i] - t;
    end
    if (arc_of(br) >= NC) begin
      corner = 1'b1; score = bs;
    end else if (arc_of(dk) >= NC) begin
      corner = 1'b1; score = ds;
    end else begin
      corner = 1'b0; score = 0;
    end
  endfunction

  // Cycle model: phase 0 idle, 1 collecting, 2 evaluating.
  int m_ph, m_cnt, m_c, m_t, m_score;
  int m_p[16];
  bit m_done, m_corner;

  always @(posedge clk) begin
    bit rc;
    int rs;
    if (n_rst) begin
      m_ph <= 0; m_cnt <= 0; m_done <= 0; m_corner <= 0; m_score <= 0;
    end else begin
      m_done <= 0;
      case (m_ph)
        0: if (sif.start) begin
          m_ph <= 1; m_cnt <= 0; m_c <= int'(sif.center); m_t <= int'(sif.thresh);
          m_corner <= 0; m_score <= 0;
        end
        1: if (sif.pix_valid) begin
          m_p[m_cnt] <= int'(sif.pix_in);
          m_cnt <= m_cnt + 1;
          if (m_cnt == 15) m_ph <= 2;
        end
        default: begin
          ref_result(m_c, m_t, m_p, rc, rs);
          m_ph <= 0; m_done <= 1; m_corner <= rc; m_score <= rs;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (init) begin
      chk("busy", int'(sif.busy), int'(m_ph != 0));
      chk("ring_idx", int'(sif.ring_idx), (m_ph == 1) ? m_cnt : 0);
      chk("done", int'(sif.done), int'(m_done));
      chk("is_corner", int'(sif.is_corner), int'(m_corner));
      chk("score", int'(sif.score), m_score);
    end
  end

  task automatic run(input int c, input int t, input int p[16], input bit gapped,
                     output int corner, output int score, output int lat);
    int k = 0;
    int e0;
    bit gap_turn = 1'b0;
    bit seen = 1'b0;
    @(negedge clk);
    sif.start = 1'b1; sif.center = PW'(c); sif.thresh = PW'(t);
    // Pixel offered in the start cycle must be ignored.
    sif.pix_valid = gapped; sif.pix_in = '0;
    e0 = cyc + 1;
    while (k < 16) begin
      @(negedge clk);
      sif.start = 1'b0;
      if (gap_turn) begin
        sif.pix_valid = 1'b0;
        sif.start = 1'b1; sif.center = '0;  // must be ignored mid-test
        gap_turn = 1'b0;
      end else begin
        sif.pix_valid = 1'b1; sif.pix_in = PW'(p[k]);
        k++;
        gap_turn = gapped;
      end
    end
    @(negedge clk);
    sif.pix_valid = 1'b0; sif.start = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (sif.done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) chk("done_timeout", 0, 1);
    corner = int'(sif.is_corner);
    score  = int'(sif.score);
    lat    = cyc - e0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p[16];
    int cr, sc, lat;
    n_rst = 1'b1;
    sif.start = 1'b0; sif.center = '0; sif.thresh = '0;
    sif.pix_valid = 1'b0; sif.pix_in = '0;
    repeat (2) @(negedge clk);
    init = 1'b1;
    chk("rst_busy", int'(sif.busy), 0);
    chk("rst_ring_idx", int'(sif.ring_idx), 0);
    chk("rst_done", int'(sif.done), 0);
    chk("rst_corner", int'(sif.is_corner), 0);
    chk("rst_score", int'(sif.score), 0);
    n_rst = 1'b0;

    for (int i = 0; i < 16; i++) p[i] = 200;
    run(100, 20, p, 1'b0, cr, sc, lat);
    chk("t1_corner", cr, 1); chk("t1_score", sc, 1280); chk("t1_latency", lat, 17);

    for (int i = 0; i < 16; i++) p[i] = (i >= 12 || i <= 4) ? 10 : 100;
    run(100, 20, p, 1'b0, cr, sc, lat);
    chk("t2_corner", cr, 1); chk("t2_score", sc, 630);

    for (int i = 0; i < 16; i++) p[i] = (i < 8) ? 130 : 100;
    run(100, 20, p, 1'b0, cr, sc, lat);
    chk("t3_corner", cr, 0); chk("t3_score", sc, 0);

    for (int i = 0; i < 16; i++) p[i] = 120;
    run(100, 20, p, 1'b0, cr, sc, lat);
    chk("t4a_corner", cr, 0); chk("t4a_score", sc, 0);

    for (int i = 0; i < 16; i++) p[i] = 121;
    run(100, 20, p, 1'b0, cr, sc, lat);
    chk("t4b_corner", cr, 1); chk("t4b_score", sc, 16);

    for (int i = 0; i < 16; i++) p[i] = 200;
    run(100, 20, p, 1'b1, cr, sc, lat);
    chk("t5_corner", cr, 1); chk("t5_score", sc, 1280); chk("t5_latency", lat, 32);

    // Reset mid-collect after 7 accepts.
    @(negedge clk);
    sif.start = 1'b1; sif.center = 8'd100; sif.thresh = 8'd20;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      sif.start = 1'b0; sif.pix_valid = 1'b1; sif.pix_in = 8'd200;
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("t6_busy", int'(sif.busy), 0);
    chk("t6_ring_idx", int'(sif.ring_idx), 0);
    chk("t6_done", int'(sif.done), 0);
    n_rst = 1'b0; sif.pix_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_done", int'(sif.done), 0);
    end

    for (int i = 0; i < 16; i++) p[i] = 200;
    run(100, 20, p, 1'b0, cr, sc, lat);
    chk("t7_corner", cr, 1); chk("t7_score", sc, 1280); chk("t7_latency", lat, 17);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
